// File: rtl/conv_feeder_pkg.sv
`default_nettype none
// ============================================================================
// conv_feeder_pkg : shared state type and size helpers for conv_layer_feeder
// Revision        : 1.0
// ============================================================================
package conv_feeder_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD_W  = 3'd1,
    LOAD_A  = 3'd2,
    COMPUTE = 3'd3,
    DRAIN   = 3'd4
  } feeder_state_t;

  function automatic int calc_out_dim(input int in_dim, input int k_dim);
    return in_dim - k_dim + 1;
  endfunction

  function automatic int calc_nw(input int n_out, input int n_in, input int k_dim);
    return n_out * n_in * k_dim * k_dim;
  endfunction

  function automatic int calc_na(input int n_in, input int in_dim);
    return n_in * in_dim * in_dim;
  endfunction

  function automatic int calc_nr(input int n_out, input int out_dim);
    return n_out * out_dim * out_dim;
  endfunction

  // Width able to hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nd_index_counter.sv
`default_nettype none
// ============================================================================
// nd_index_counter : 4-digit mixed-radix counter, digit 0 innermost
// Revision         : 1.0
// ============================================================================
module nd_index_counter
  import conv_feeder_pkg::*;
#(
  parameter int DW = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic               i_inc,
  input  logic [3:0][DW-1:0] i_max,
  output logic [3:0][DW-1:0] o_idx,
  output logic               o_last
);

  logic [3:0][DW-1:0] r_idx;
  logic [3:0]         w_wrap;
  logic [3:0]         w_carry;

  always_comb begin
    w_wrap = '0;
    for (int d = 0; d < 4; d++) begin
      w_wrap[d] = (r_idx[d] == i_max[d]);
    end
  end

  // A digit advances only when every less-significant digit is wrapping.
  assign w_carry[0]   = i_inc;
  assign w_carry[3:1] = w_carry[2:0] & w_wrap[2:0];

  always_ff @(posedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (rst || i_clear) begin
        r_idx[d] <= '0;
      end else if (w_carry[d]) begin
        r_idx[d] <= w_wrap[d] ? '0 : r_idx[d] + DW'(1);
      end
    end
  end

  assign o_idx  = r_idx;
  assign o_last = &w_wrap;

endmodule
`default_nettype wire

// File: rtl/conv_layer_feeder.sv
`default_nettype none
// ============================================================================
// conv_layer_feeder : streams host words into conv_layer as weight/activation
//                     writes, fires compute, then counts result beats
// Revision          : 1.0
// ============================================================================
module conv_layer_feeder
  import conv_feeder_pkg::*;
#(
  parameter int NUM_INPUTS  = 2,
  parameter int INPUT_DIM   = 5,
  parameter int NUM_OUTPUTS = 2,
  parameter int KERNEL_DIM  = 3,
  parameter int DATA_SIZE   = 64,
  parameter int INDEX_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 load_weights,
  input  logic [DATA_SIZE-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [DATA_SIZE-1:0] write_data,
  output logic                 want_write_weights,
  output logic                 want_write_act,
  output logic [INDEX_W-1:0]   in_index3,
  output logic [INDEX_W-1:0]   in_index2,
  output logic [INDEX_W-1:0]   in_index1,
  output logic [INDEX_W-1:0]   in_index0,
  output logic                 compute,
  input  logic                 output_valid,
  output logic                 busy,
  output logic                 frame_done
);

  localparam int c_out_dim = calc_out_dim(INPUT_DIM, KERNEL_DIM);
  localparam int c_nr      = calc_nr(NUM_OUTPUTS, c_out_dim);
  localparam int c_dw      = cnt_width(max4(NUM_OUTPUTS, NUM_INPUTS, KERNEL_DIM, INPUT_DIM));
  localparam int c_rw      = cnt_width(c_nr + 1);

  localparam logic [3:0][c_dw-1:0] c_w_max = {
    c_dw'(NUM_OUTPUTS - 1), c_dw'(NUM_INPUTS - 1),
    c_dw'(KERNEL_DIM - 1),  c_dw'(KERNEL_DIM - 1)
  };
  localparam logic [3:0][c_dw-1:0] c_a_max = {
    c_dw'(0),              c_dw'(NUM_INPUTS - 1),
    c_dw'(INPUT_DIM - 1),  c_dw'(INPUT_DIM - 1)
  };

  feeder_state_t           r_state;
  feeder_state_t           w_next;
  logic                    w_accept;
  logic                    w_last;
  logic                    w_in_result;
  logic                    w_count_en;
  logic                    w_hit;
  logic [3:0][c_dw-1:0]    w_max;
  logic [3:0][c_dw-1:0]    w_idx;
  logic [c_rw-1:0]         r_res_cnt;

  logic [DATA_SIZE-1:0]    r_write_data;
  logic                    r_want_w;
  logic                    r_want_a;
  logic [INDEX_W-1:0]      r_idx3;
  logic [INDEX_W-1:0]      r_idx2;
  logic [INDEX_W-1:0]      r_idx1;
  logic [INDEX_W-1:0]      r_idx0;
  logic                    r_compute;
  logic                    r_busy;
  logic                    r_frame_done;

  assign s_ready  = (r_state == LOAD_W) || (r_state == LOAD_A);
  assign w_accept = s_valid && s_ready;

  // One counter serves both phases; the final weight beat wraps it to zero
  // exactly as the activation radices take over.
  assign w_max = (r_state == LOAD_W) ? c_w_max : c_a_max;

  nd_index_counter #(
    .DW (c_dw)
  ) u_index (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == IDLE),
    .i_inc   (w_accept),
    .i_max   (w_max),
    .o_idx   (w_idx),
    .o_last  (w_last)
  );

  assign w_in_result = (r_state == COMPUTE) || (r_state == DRAIN);
  assign w_count_en  = w_in_result && output_valid && !r_frame_done;
  assign w_hit       = w_count_en && (r_res_cnt == c_rw'(c_nr - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (start) w_next = load_weights ? LOAD_W : LOAD_A;
      LOAD_W:  if (w_accept && w_last) w_next = LOAD_A;
      LOAD_A:  if (w_accept && w_last) w_next = COMPUTE;
      COMPUTE: w_next = DRAIN;
      DRAIN:   if (r_frame_done) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !w_in_result || r_frame_done) begin
      r_res_cnt <= '0;
    end else if (w_count_en) begin
      r_res_cnt <= r_res_cnt + c_rw'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_write_data <= '0;
      r_want_w     <= 1'b0;
      r_want_a     <= 1'b0;
      r_idx3       <= '0;
      r_idx2       <= '0;
      r_idx1       <= '0;
      r_idx0       <= '0;
      r_compute    <= 1'b0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_want_w     <= w_accept && (r_state == LOAD_W);
      r_want_a     <= w_accept && (r_state == LOAD_A);
      if (w_accept) begin
        r_write_data <= s_data;
        r_idx3       <= INDEX_W'(w_idx[3]);
        r_idx2       <= INDEX_W'(w_idx[2]);
        r_idx1       <= INDEX_W'(w_idx[1]);
        r_idx0       <= INDEX_W'(w_idx[0]);
      end
      r_compute    <= (r_state == COMPUTE);
      r_busy       <= (w_next != IDLE);
      r_frame_done <= w_hit;
    end
  end

  assign write_data         = r_write_data;
  assign want_write_weights = r_want_w;
  assign want_write_act     = r_want_a;
  assign in_index3          = r_idx3;
  assign in_index2          = r_idx2;
  assign in_index1          = r_idx1;
  assign in_index0          = r_idx0;
  assign compute            = r_compute;
  assign busy               = r_busy;
  assign frame_done         = r_frame_done;

endmodule
`default_nettype wire

// File: doc/conv_layer_feeder.md
Name: conv_layer_feeder

Overview:
- Transmit side of the conv_layer load/compute interface.
- Accepts a host stream of 64-bit words (IEEE-754 double bit patterns) on a valid/ready port.
- Auto-generates the 4-D write indices, issues weight writes and then activation writes, pulses compute, and counts result beats until the frame completes.
- Sits between the host/testbench source and a conv_layer instance, replacing hand-driven index/strobe stimulus.

Parameters:
- NUM_INPUTS, 2, input channels.
- INPUT_DIM, 5, input feature-map edge length.
- NUM_OUTPUTS, 2, output channels.
- KERNEL_DIM, 3, kernel edge length.
- DATA_SIZE, 64, data word width.
- INDEX_W, 16, width of each index output.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  begin frame; sampled in IDLE only.
- load_weights  in  1  sampled with start; 1 = weights then activations, 0 = activations only.
- s_data  in  DATA_SIZE  host word.
- s_valid  in  1  host word valid.
- s_ready  out  1  feeder accepts word.
- write_data  out  DATA_SIZE  to conv_layer write_data.
- want_write_weights  out  1  weight write strobe.
- want_write_act  out  1  activation write strobe.
- in_index3  out  INDEX_W  weights: out channel; activations: 0.
- in_index2  out  INDEX_W  weights: in channel; activations: in channel.
- in_index1  out  INDEX_W  row.
- in_index0  out  INDEX_W  column.
- compute  out  1  one-cycle compute pulse.
- output_valid  in  1  result beat from conv_layer.
- busy  out  1  high in any state except IDLE.
- frame_done  out  1  one-cycle pulse when all results are counted.

Behaviour:
- Derived constants:
  - OUT_DIM = INPUT_DIM-KERNEL_DIM+1.
  - NW = NUM_OUTPUTS*NUM_INPUTS*KERNEL_DIM^2 (default 36).
  - NA = NUM_INPUTS*INPUT_DIM^2 (default 50).
  - NR = NUM_OUTPUTS*OUT_DIM^2 (default 18).
- Reset (synchronous, rst=1 at posedge):
  - State goes to IDLE.
  - All outputs 0: s_ready, strobes, indices, write_data, compute, busy, frame_done.
  - All counters cleared.
  - Applies from any state, including mid-load.
- States: IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN.
- IDLE:
  - s_ready=0.
  - start=1 goes to LOAD_W if load_weights=1, else LOAD_A.
- LOAD_W / LOAD_A:
  - s_ready=1, except combinationally 0 in the cycle after the final beat of LOAD_A is accepted.
  - Accepted beat = s_valid&s_ready.
  - Each accepted beat produces exactly one registered write cycle on the next clock: the strobe is high for one cycle, with write_data=s_data and the indices for that beat.
  - No write cycle without an accepted beat; s_valid low simply stalls.
- Index order, column innermost, each counter wrapping to 0 and carrying into the next:
  - Weights: [index3=out][index2=in][index1=kr][index0=kc].
  - Activations: [in][row][col], with index3=0.
- Transitions out of the load states:
  - After beat NW is accepted, LOAD_W goes to LOAD_A. The first activation can be accepted in the very next cycle (no bubble).
  - After beat NA is accepted, LOAD_A goes to COMPUTE.
- COMPUTE:
  - compute=1 for exactly one cycle, in the cycle after the last activation write strobe.
  - Then go to DRAIN.
- DRAIN:
  - Count output_valid pulses; output_valid is also counted during the COMPUTE cycle.
  - When the count reaches NR: frame_done=1 for one cycle, then IDLE.
  - Count cleared on leaving DRAIN.
- Ignored events:
  - output_valid in IDLE/LOAD_* is ignored (not counted).
  - start while busy is ignored.
  - Extra s_valid after the final beat is not accepted (s_ready=0).
- busy is registered: rises the cycle after start is accepted, falls with the frame_done cycle's successor.
- Counter widths are computed with $clog2 of their terminal values; indices are zero-extended to INDEX_W.

Decomposition:
- Package conv_feeder_pkg holds:
  - the state enum (IDLE, LOAD_W, LOAD_A, COMPUTE, DRAIN);
  - constant functions computing OUT_DIM/NW/NA/NR from the parameters.
- One sub-module, nd_index_counter: a 4-digit mixed-radix counter with per-digit limits, increment enable, clear, and last flag. It is instantiated once and reconfigured by state (weight radices vs activation radices).

Test Plan:
- Reset, then start with load_weights=1, continuous s_valid, 86 words with value k as bit pattern:
  - 36 weight strobes with index progression (0,0,0,0), (0,0,0,1)…(1,1,2,2);
  - then 50 act strobes (0,0,0,0)…(0,1,4,4);
  - compute pulse exactly 1 cycle after the final act strobe.
- load_weights=0:
  - no weight strobes; the first act strobe is at index (0,0,0,0) on the cycle after the first accepted word.
- s_valid toggling 1,0,1,0:
  - strobes appear only after accepted beats;
  - data order preserved;
  - indices never skip.
- After compute, drive 18 output_valid pulses with gaps:
  - frame_done pulses on the clock after the 18th;
  - busy drops;
  - 17 pulses yield no frame_done.
- Assert rst mid-LOAD_A after 20 act beats:
  - next cycle all outputs 0, state IDLE;
  - a new start restarts indices from (0,0,0,0).
- start asserted during DRAIN and output_valid during LOAD_W:
  - both ignored;
  - frame still requires exactly 18 pulses in COMPUTE/DRAIN.
